// File: rtl/outreg_drain_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// outreg_ctrl_pkg
// Shared types and helpers for the output-register drain controller.
//   drain_state_t : job FSM states (IDLE, RUN, DONE)
//   rr_next()     : round-robin pointer advance with wrap at nreq
// ----------------------------------------------------------------------------
package outreg_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drain_state_t;

    // Next round-robin pointer: one past the winner, wrapping to 0 at nreq.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
        int unsigned nxt;
        if ((ptr + 32'd1) >= nreq) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/outreg_drain_ctrl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at ptr and
// walks ptr, ptr+1, ... wrapping mod NREQ; the first valid requester wins.
// Ports:
//   req     in  NREQ  request vector
//   ptr     in  IW    highest-priority index this cycle
//   en      in  1     arbitration enable; no grant when low
//   gnt     out NREQ  one-hot grant (or zero)
//   gnt_idx out IW    index of the granted requester (0 when no grant)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    // Rotating priority search; the found flag keeps the grant one-hot.
    always_comb begin
        logic          found;
        int            idx;
        logic [IW-1:0] sel;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            sel = IW'(idx);
            if (en && !found && req[sel]) begin
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
                found    = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/outreg_drain_ctrl.sv
// ----------------------------------------------------------------------------
// outreg_drain_ctrl
// Round-robin collector: arbitrates NREQ PE result streams into a single
// holding register, drains it on a valid/ready stream and counts words
// against a programmed job length, raising Done when the job has drained.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   Start, Expected_Count      job start pulse and job length (words)
//   Req_Valid/Req_Data         per-PE result streams
//   Req_Grant                  combinational one-hot accept back to the PEs
//   Out_Valid/Out_Ready        output handshake; Out_Data/Out_Src payload
//   Busy, Done, Emitted_Count  job status
// ----------------------------------------------------------------------------
module outreg_drain_ctrl
    import outreg_ctrl_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NREQ   = 4,
    parameter int CWIDTH = 16,
    parameter int SW     = $clog2(NREQ)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [CWIDTH-1:0]      Expected_Count,
    input  logic [NREQ-1:0]        Req_Valid,
    input  logic [NREQ*DWIDTH-1:0] Req_Data,
    output logic [NREQ-1:0]        Req_Grant,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [DWIDTH-1:0]      Out_Data,
    output logic [SW-1:0]          Out_Src,
    output logic                   Busy,
    output logic                   Done,
    output logic [CWIDTH-1:0]      Emitted_Count
);

    drain_state_t      state_q,     state_d;
    logic [CWIDTH-1:0] expected_q,  expected_d;
    logic [CWIDTH-1:0] accepted_q,  accepted_d;
    logic [CWIDTH-1:0] emitted_q,   emitted_d;
    logic [SW-1:0]     ptr_q,       ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] out_data_q,  out_data_d;
    logic [SW-1:0]     out_src_q,   out_src_d;

    logic              slot_free_s;
    logic              arb_en_s;
    logic              drain_s;
    logic              grant_any_s;
    logic [NREQ-1:0]   gnt_s;
    logic [SW-1:0]     gnt_idx_s;
    logic [CWIDTH-1:0] emitted_inc_s;

    // Same-cycle drain and refill is allowed, so the slot is free when the
    // sink is taking the current word.
    assign slot_free_s   = !out_valid_q || Out_Ready;
    assign arb_en_s      = (state_q == RUN) && (accepted_q < expected_q) && slot_free_s;
    assign drain_s       = out_valid_q && Out_Ready;
    assign grant_any_s   = |gnt_s;
    assign emitted_inc_s = emitted_q + CWIDTH'(1'b1);

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (SW)
    ) u_arb (
        .req     (Req_Valid),
        .ptr     (ptr_q),
        .en      (arb_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Next-state logic for FSM, counters, RR pointer and holding register.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        accepted_d  = accepted_q;
        emitted_d   = emitted_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    expected_d = Expected_Count;
                    accepted_d = '0;
                    emitted_d  = '0;
                    if (Expected_Count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (grant_any_s) begin
                    accepted_d = accepted_q + CWIDTH'(1'b1);
                end else begin
                    accepted_d = accepted_q;
                end
                if (drain_s) begin
                    emitted_d = emitted_inc_s;
                    // Every granted word is drained before the count can match,
                    // so the holding register is empty on entry to DONE.
                    if (emitted_inc_s == expected_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    emitted_d = emitted_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Holding register: load on grant, empty only on drain without refill.
        if (grant_any_s) begin
            out_valid_d = 1'b1;
            out_data_d  = Req_Data[int'(gnt_idx_s)*DWIDTH +: DWIDTH];
            out_src_d   = gnt_idx_s;
            ptr_d       = SW'(rr_next(int'(gnt_idx_s), NREQ));
        end else if (drain_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset that drops any held word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            expected_q  <= '0;
            accepted_q  <= '0;
            emitted_q   <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            accepted_q  <= accepted_d;
            emitted_q   <= emitted_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign Req_Grant     = gnt_s;
    assign Out_Valid     = out_valid_q;
    assign Out_Data      = out_data_q;
    assign Out_Src       = out_src_q;
    assign Busy          = (state_q == RUN);
    assign Done          = (state_q == DONE);
    assign Emitted_Count = emitted_q;

endmodule

// File: tb/tb_outreg_drain_ctrl.sv
// ----------------------------------------------------------------------------
// tb_outreg_drain_ctrl
// Directed self-checking bench for outreg_drain_ctrl (DWIDTH=32, NREQ=4,
// CWIDTH=16). Inputs change 1 time unit after the rising edge and outputs
// are sampled 1 unit later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_outreg_drain_ctrl;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int CW = 16;

    logic              Clk;
    logic              Reset;
    logic              Start;
    logic [CW-1:0]     Expected_Count;
    logic [NR-1:0]     Req_Valid;
    logic [NR*DW-1:0]  Req_Data;
    logic [NR-1:0]     Req_Grant;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [DW-1:0]     Out_Data;
    logic [1:0]        Out_Src;
    logic              Busy;
    logic              Done;
    logic [CW-1:0]     Emitted_Count;

    int                check_cnt;
    int                error_cnt;
    logic [33:0]       sb_q[$];

    outreg_drain_ctrl #(
        .DWIDTH (DW),
        .NREQ   (NR),
        .CWIDTH (CW)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Start          (Start),
        .Expected_Count (Expected_Count),
        .Req_Valid      (Req_Valid),
        .Req_Data       (Req_Data),
        .Req_Grant      (Req_Grant),
        .Out_Valid      (Out_Valid),
        .Out_Ready      (Out_Ready),
        .Out_Data       (Out_Data),
        .Out_Src        (Out_Src),
        .Busy           (Busy),
        .Done           (Done),
        .Emitted_Count  (Emitted_Count)
    );

    // Free-running clock, period 10.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Hard stop in case something unforeseen stalls the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_pe(input int i, input logic [31:0] d);
        Req_Data[i*DW +: DW] = d;
    endtask

    task automatic start_job(input logic [CW-1:0] n);
        Start          = 1'b1;
        Expected_Count = n;
        tick();
        Start          = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!Done && n < 30) begin
            tick();
            n++;
        end
        check_val(tag, 64'(Done), 64'd1);
    endtask

    task automatic sb_pop();
        logic [33:0] exp_w;
        if (Out_Valid) begin
            check_val("t6_sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_w = sb_q.pop_front();
                check_val("t6_word", 64'({Out_Src, Out_Data}), 64'(exp_w));
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        int          pe;
        check_cnt      = 0;
        error_cnt      = 0;
        Reset          = 1'b1;
        Start          = 1'b0;
        Expected_Count = '0;
        Req_Valid      = '0;
        Req_Data       = '0;
        Out_Ready      = 1'b1;
        tick();
        tick();

        // Reset state
        check_val("rst_valid",   64'(Out_Valid), 64'd0);
        check_val("rst_data",    64'(Out_Data), 64'd0);
        check_val("rst_src",     64'(Out_Src), 64'd0);
        check_val("rst_busy",    64'(Busy), 64'd0);
        check_val("rst_done",    64'(Done), 64'd0);
        check_val("rst_emitted", 64'(Emitted_Count), 64'd0);
        Reset = 1'b0;

        // Test 1: PE2 only, 3 words, no 4th grant
        start_job(16'd3);
        for (int k = 0; k < 4; k++) begin
            Req_Valid = 4'b0100;
            set_pe(2, 32'h2000_0000 + 32'(k));
            #1;
            check_val("t1_grant", 64'(Req_Grant), (k < 3) ? 64'h4 : 64'h0);
            if (k >= 1) begin
                check_val("t1_valid", 64'(Out_Valid), 64'd1);
                check_val("t1_src",   64'(Out_Src), 64'd2);
                check_val("t1_data",  64'(Out_Data), 64'(32'h2000_0000 + 32'(k - 1)));
            end
            tick();
        end
        check_val("t1_done",    64'(Done), 64'd1);
        check_val("t1_busy",    64'(Busy), 64'd0);
        check_val("t1_valid0",  64'(Out_Valid), 64'd0);
        check_val("t1_emitted", 64'(Emitted_Count), 64'd3);
        check_val("t1_nogrant", 64'(Req_Grant), 64'd0);

        // Test 2: all PEs valid, 8 words, strict rotation from PE0
        Reset = 1'b1;
        tick();
        Reset     = 1'b0;
        Req_Valid = 4'b1111;
        start_job(16'd8);
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < NR; i++) begin
                set_pe(i, (32'(i) << 24) | 32'(k));
            end
            #1;
            check_val("t2_grant", 64'(Req_Grant), (k < 8) ? 64'(1 << (k % 4)) : 64'h0);
            if (k >= 1) begin
                check_val("t2_src",     64'(Out_Src), 64'((k - 1) % 4));
                check_val("t2_data",    64'(Out_Data), 64'((32'((k - 1) % 4) << 24) | 32'(k - 1)));
                check_val("t2_emitted", 64'(Emitted_Count), 64'(k - 1));
            end
            tick();
        end
        check_val("t2_done",    64'(Done), 64'd1);
        check_val("t2_emitted", 64'(Emitted_Count), 64'd8);

        // Test 3: stall with 0xDEADBEEF held, then drain+refill in one cycle
        Req_Valid = 4'b0010;
        Out_Ready = 1'b0;
        set_pe(1, 32'hDEAD_BEEF);
        start_job(16'd3);
        #1;
        check_val("t3_grant0", 64'(Req_Grant), 64'h2);
        tick();
        for (int s = 0; s < 5; s++) begin
            set_pe(1, 32'hCAFE_F00D);
            #1;
            check_val("t3_hold_valid", 64'(Out_Valid), 64'd1);
            check_val("t3_hold_data",  64'(Out_Data), 64'hDEAD_BEEF);
            check_val("t3_hold_src",   64'(Out_Src), 64'd1);
            check_val("t3_hold_grant", 64'(Req_Grant), 64'd0);
            tick();
        end
        Out_Ready = 1'b1;
        #1;
        check_val("t3_refill_grant", 64'(Req_Grant), 64'h2);
        check_val("t3_emitted0",     64'(Emitted_Count), 64'd0);
        tick();
        check_val("t3_refill_data",  64'(Out_Data), 64'hCAFE_F00D);
        check_val("t3_refill_valid", 64'(Out_Valid), 64'd1);
        check_val("t3_emitted1",     64'(Emitted_Count), 64'd1);
        wait_done("t3_done");
        check_val("t3_emitted", 64'(Emitted_Count), 64'd3);

        // Test 4: zero-length job, then Start ignored during RUN
        Req_Valid = 4'b1111;
        start_job(16'd0);
        #1;
        check_val("t4_done0",    64'(Done), 64'd1);
        check_val("t4_busy0",    64'(Busy), 64'd0);
        check_val("t4_emitted0", 64'(Emitted_Count), 64'd0);
        check_val("t4_grant0",   64'(Req_Grant), 64'd0);
        Req_Valid = 4'b0000;
        start_job(16'd4);
        check_val("t4_busy1", 64'(Busy), 64'd1);
        start_job(16'd1);
        check_val("t4_busy2",    64'(Busy), 64'd1);
        check_val("t4_emitted1", 64'(Emitted_Count), 64'd0);
        Req_Valid = 4'b0001;
        wait_done("t4_done");
        check_val("t4_emitted", 64'(Emitted_Count), 64'd4);

        // Test 5: reset after 2 of 5 words, then a clean 2-word job
        Req_Valid = 4'b0010;
        start_job(16'd5);
        tick();
        tick();
        tick();
        check_val("t5_emitted2", 64'(Emitted_Count), 64'd2);
        Reset = 1'b1;
        tick();
        check_val("t5_valid",   64'(Out_Valid), 64'd0);
        check_val("t5_data",    64'(Out_Data), 64'd0);
        check_val("t5_src",     64'(Out_Src), 64'd0);
        check_val("t5_busy",    64'(Busy), 64'd0);
        check_val("t5_done",    64'(Done), 64'd0);
        check_val("t5_emitted", 64'(Emitted_Count), 64'd0);
        check_val("t5_grant",   64'(Req_Grant), 64'd0);
        Reset     = 1'b0;
        Req_Valid = 4'b1111;
        start_job(16'd2);
        #1;
        check_val("t5_ptr0", 64'(Req_Grant), 64'h1);
        tick();
        check_val("t5_ptr1", 64'(Req_Grant), 64'h2);
        check_val("t5_src0", 64'(Out_Src), 64'd0);
        wait_done("t5_done2");
        check_val("t5_emitted_end", 64'(Emitted_Count), 64'd2);

        // Test 6: PE3/PE0 alternating with scoreboard on every word
        Req_Valid = 4'b0000;
        start_job(16'd6);
        for (int k = 0; k < 6; k++) begin
            pe        = (k % 2 == 0) ? 3 : 0;
            Req_Valid = 4'(1 << pe);
            w         = 32'h6000_0000 | (32'(k) << 8) | 32'(pe);
            set_pe(pe, w);
            #1;
            sb_pop();
            check_val("t6_grant", 64'(Req_Grant), 64'(1 << pe));
            sb_q.push_back({2'(pe), w});
            tick();
        end
        Req_Valid = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            sb_pop();
            tick();
        end
        check_val("t6_done",    64'(Done), 64'd1);
        check_val("t6_emitted", 64'(Emitted_Count), 64'd6);
        check_val("t6_sb_left", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
